// File: rtl/ps2_key_pkg.sv
// Shared scan codes, action bit positions and event width for the PS/2 key event path.
// Scan codes are 9-bit {ext, code} values from scan set 2.
package ps2_key_pkg;
   localparam int EVT_W   = 10;
   localparam int NUM_ACT = 7;

   localparam logic [8:0] KEY_W       = 9'h01D;
   localparam logic [8:0] KEY_A       = 9'h01C;
   localparam logic [8:0] KEY_S       = 9'h01B;
   localparam logic [8:0] KEY_D       = 9'h023;
   localparam logic [8:0] KEY_SPACE   = 9'h029;
   localparam logic [8:0] KEY_ENTER   = 9'h05A;
   localparam logic [8:0] KEY_ESC     = 9'h076;
   localparam logic [8:0] KEY_UP_E    = 9'h175;
   localparam logic [8:0] KEY_DOWN_E  = 9'h172;
   localparam logic [8:0] KEY_LEFT_E  = 9'h16B;
   localparam logic [8:0] KEY_RIGHT_E = 9'h174;

   localparam int ACT_UP    = 0;
   localparam int ACT_DOWN  = 1;
   localparam int ACT_LEFT  = 2;
   localparam int ACT_RIGHT = 3;
   localparam int ACT_FIRE  = 4;
   localparam int ACT_START = 5;
   localparam int ACT_ESC   = 6;

   // One-hot action mask for a pressed key; zero for unmapped codes.
   function automatic logic [NUM_ACT-1:0] act_decode(input logic [8:0] k);
      logic [NUM_ACT-1:0] m;
      m = '0;
      case (k)
         KEY_W,     KEY_UP_E:    m[ACT_UP]    = 1'b1;
         KEY_S,     KEY_DOWN_E:  m[ACT_DOWN]  = 1'b1;
         KEY_A,     KEY_LEFT_E:  m[ACT_LEFT]  = 1'b1;
         KEY_D,     KEY_RIGHT_E: m[ACT_RIGHT] = 1'b1;
         KEY_SPACE:              m[ACT_FIRE]  = 1'b1;
         KEY_ENTER:              m[ACT_START] = 1'b1;
         KEY_ESC:                m[ACT_ESC]   = 1'b1;
         default:                m            = '0;
      endcase
      return m;
   endfunction
endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous FIFO, registered head, no fall-through. A push while full is
// accepted only when a pop frees a slot in the same cycle.
module ps2_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 10,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;
   logic          w_wr, w_rd;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_rd    = i_pop & ~o_empty;
   assign w_wr    = i_push & (~o_full | w_rd);

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rptr];
   assign o_count = r_count;
endmodule

// File: rtl/ps2_key_events.sv
// Converts PS/2 receiver level output into queued press/release events and
// tracks a held-state bitmap of mapped game actions.
module ps2_key_events
   import ps2_key_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int AW         = $clog2(FIFO_DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [8:0]        i_key_data,
   output logic              o_evt_valid,
   input  logic              i_evt_ready,
   output logic [EVT_W-1:0]  o_evt_data,
   output logic [NUM_ACT-1:0] o_actions,
   output logic              o_overflow,
   output logic [AW:0]       o_evt_count
);
   logic [8:0]         r_cur, r_prev;
   logic [NUM_ACT-1:0] r_actions;
   logic               r_overflow;
   logic               w_push, w_pop, w_full, w_empty, w_release;
   logic [EVT_W-1:0]   w_evt;

   assign w_push    = (r_cur != r_prev);
   assign w_release = (r_cur == '0);
   // A break carries no key identity, so the release event names the last held code.
   assign w_evt     = w_release ? {1'b1, r_prev} : {1'b0, r_cur};
   assign w_pop     = o_evt_valid & i_evt_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cur      <= '0;
         r_prev     <= '0;
         r_actions  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_cur  <= i_key_data;
         r_prev <= r_cur;
         if (w_push) begin
            if (w_release) r_actions <= '0;
            else           r_actions <= r_actions | act_decode(r_cur);
         end
         if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
      end
   end

   ps2_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EVT_W),
      .AW    (AW)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_data  (w_evt),
      .i_pop   (w_pop),
      .o_data  (o_evt_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (o_evt_count)
   );

   assign o_evt_valid = ~w_empty;
   assign o_actions   = r_actions;
   assign o_overflow  = r_overflow;
endmodule

// File: tb/tb_ps2_key_events.sv
// Directed bench for ps2_key_events: inputs driven and outputs sampled on the falling edge.
module tb_ps2_key_events;
   logic       clk = 1'b0;
   logic       rst;
   logic [8:0] key_data;
   logic       evt_valid, evt_ready, overflow;
   logic [9:0] evt_data;
   logic [6:0] actions;
   logic [2:0] evt_count;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         nval;

   always #5 clk = ~clk;

   ps2_key_events #(.FIFO_DEPTH(4)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_key_data  (key_data),
      .o_evt_valid (evt_valid),
      .i_evt_ready (evt_ready),
      .o_evt_data  (evt_data),
      .o_actions   (actions),
      .o_overflow  (overflow),
      .o_evt_count (evt_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; key_data = '0; evt_ready = 1'b1;
      nclk(2);
      chk("rst_valid", 32'(evt_valid), 0);
      chk("rst_count", 32'(evt_count), 0);
      chk("rst_actions", 32'(actions), 0);
      chk("rst_ovf", 32'(overflow), 0);
      rst = 1'b0;
      nclk(1);

      // press W, held for 100 cycles
      key_data = 9'h01D;
      nclk(2);
      chk("w_valid", 32'(evt_valid), 1);
      chk("w_data", 32'(evt_data), 32'h01D);
      chk("w_actions", 32'(actions), 32'h01);
      nval = 0;
      for (int i = 0; i < 100; i++) begin
         nclk(1);
         if (evt_valid) nval++;
      end
      chk("w_held_noevt", 32'(nval), 0);

      key_data = 9'h000;
      nclk(2);
      chk("w_rel_data", 32'(evt_data), 32'h21D);
      chk("w_rel_valid", 32'(evt_valid), 1);
      chk("w_rel_actions", 32'(actions), 0);
      nclk(2);

      // extended up arrow press / release
      key_data = 9'h175;
      nclk(2);
      chk("up_e_data", 32'(evt_data), 32'h175);
      chk("up_e_actions", 32'(actions), 32'h01);
      key_data = 9'h000;
      nclk(2);
      chk("up_e_rel_data", 32'(evt_data), 32'h375);
      chk("up_e_rel_actions", 32'(actions), 0);
      nclk(2);
      chk("idle_count", 32'(evt_count), 0);

      // five presses with consumer stalled: the fifth is dropped
      evt_ready = 1'b0;
      key_data = 9'h01D; nclk(1);
      key_data = 9'h01C; nclk(1);
      key_data = 9'h01B; nclk(1);
      key_data = 9'h023; nclk(1);
      key_data = 9'h029; nclk(2);
      chk("ovf_count", 32'(evt_count), 4);
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_actions", 32'(actions), 32'h1F);
      chk("ovf_hold_data", 32'(evt_data), 32'h01D);
      nclk(1);
      chk("ovf_hold_stable", 32'(evt_data), 32'h01D);
      evt_ready = 1'b1;
      chk("drain0", 32'(evt_data), 32'h01D); nclk(1);
      chk("drain1", 32'(evt_data), 32'h01C); nclk(1);
      chk("drain2", 32'(evt_data), 32'h01B); nclk(1);
      chk("drain3", 32'(evt_data), 32'h023); nclk(1);
      chk("drain_empty", 32'(evt_valid), 0);
      chk("ovf_sticky", 32'(overflow), 1);

      // reset, then push into a full FIFO while popping
      rst = 1'b1; key_data = '0; evt_ready = 1'b0;
      nclk(1);
      rst = 1'b0;
      chk("rst2_ovf", 32'(overflow), 0);
      key_data = 9'h01D; nclk(1);
      key_data = 9'h01C; nclk(1);
      key_data = 9'h01B; nclk(1);
      key_data = 9'h023; nclk(1);
      key_data = 9'h029; nclk(1);
      chk("full_count", 32'(evt_count), 4);
      evt_ready = 1'b1;
      nclk(1);
      evt_ready = 1'b0;
      chk("pp_count", 32'(evt_count), 4);
      chk("pp_ovf", 32'(overflow), 0);
      chk("pp_head", 32'(evt_data), 32'h01C);
      evt_ready = 1'b1;
      chk("pp_drain0", 32'(evt_data), 32'h01C); nclk(1);
      chk("pp_drain1", 32'(evt_data), 32'h01B); nclk(1);
      chk("pp_drain2", 32'(evt_data), 32'h023); nclk(1);
      chk("pp_drain3", 32'(evt_data), 32'h029); nclk(1);
      chk("pp_empty", 32'(evt_count), 0);

      // reset with three events queued and actions set
      evt_ready = 1'b0;
      key_data = 9'h01D; nclk(1);
      key_data = 9'h01C; nclk(1);
      key_data = 9'h01B; nclk(2);
      chk("pre_rst_count", 32'(evt_count), 3);
      chk("pre_rst_actions", 32'(actions), 32'h1F);
      rst = 1'b1; key_data = 9'h029;
      nclk(1);
      rst = 1'b0;
      chk("rst3_valid", 32'(evt_valid), 0);
      chk("rst3_count", 32'(evt_count), 0);
      chk("rst3_actions", 32'(actions), 0);
      chk("rst3_ovf", 32'(overflow), 0);
      nclk(2);
      chk("post_rst_valid", 32'(evt_valid), 1);
      chk("post_rst_data", 32'(evt_data), 32'h029);
      chk("post_rst_actions", 32'(actions), 32'h10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
